// File: rtl/uart_response_serializer.sv
// Streams a latched response payload (byte 0 first) to the UART TX over valid/ready, then appends TERM_HI, TERM_LO.
// First byte is offered the cycle after start; a stall of TIMEOUT cycles without a handshake aborts with error.
module uart_response_serializer #(
  parameter int         MAX_BYTES = 128,
  parameter int         TIMEOUT   = 1026,
  parameter logic [7:0] TERM_HI   = 8'hBE,
  parameter logic [7:0] TERM_LO   = 8'hEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [MAX_BYTES*8-1:0] input_data,
  input  logic [7:0]             input_data_size,
  input  logic                   start,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int             IW       = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [8:0]     MAX_SZ   = 9'(MAX_BYTES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, TERM0, TERM1} state_t;

  state_t        state, state_n;
  logic [7:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          done_n, error_n;
  logic          load;
  logic [7:0]    size_q;
  logic [7:0]    pay_q [MAX_BYTES];
  logic          hs;

  assign tx_valid = (state != IDLE);
  assign busy     = (state != IDLE);
  assign hs       = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= 8'd0;
      cnt   <= '0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      done  <= done_n;
      error <= error_n;
    end
  end

  // Payload storage is only written on an accepted start, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      size_q <= input_data_size;
      for (int k = 0; k < MAX_BYTES; k++) begin
        pay_q[k] <= input_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    done_n  = done;
    error_n = error;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          done_n  = 1'b0;
          error_n = 1'b0;
          cnt_n   = '0;
          idx_n   = 8'd0;
          if ({1'b0, input_data_size} > MAX_SZ) begin
            error_n = 1'b1;
          end else if (input_data_size == 8'd0) begin
            state_n = TERM0;
          end else begin
            state_n = PAYLOAD;
          end
        end
      end
      default: begin
        if (hs) begin
          cnt_n = '0;
          case (state)
            PAYLOAD: begin
              idx_n = idx + 8'd1;
              if ((idx + 8'd1) == size_q) begin
                state_n = TERM0;
              end
            end
            TERM0:   state_n = TERM1;
            default: begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          endcase
        end else if (cnt == CNT_LAST) begin
          // This edge completes the TIMEOUT-th stalled cycle: abandon the transfer.
          state_n = IDLE;
          cnt_n   = '0;
          error_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    tx_data = 8'h00;
    case (state)
      PAYLOAD: tx_data = pay_q[idx[IW-1:0]];
      TERM0:   tx_data = TERM_HI;
      TERM1:   tx_data = TERM_LO;
      default: tx_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_response_serializer.sv
// Directed and randomized bench for uart_response_serializer; expected byte streams come from a queue model.
module tb_uart_response_serializer;

  localparam int MB = 128;
  localparam int TO = 1026;

  logic            clk = 1'b0;
  logic            reset;
  logic [MB*8-1:0] input_data;
  logic [7:0]      input_data_size;
  logic            start;
  logic            tx_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            busy;
  logic            done;
  logic            error;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] pay [MB];

  always #5 clk = ~clk;

  uart_response_serializer #(
    .MAX_BYTES(MB),
    .TIMEOUT  (TO),
    .TERM_HI  (8'hBE),
    .TERM_LO  (8'hEF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .input_data     (input_data),
    .input_data_size(input_data_size),
    .start          (start),
    .tx_ready       (tx_ready),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_inputs(input int size);
    for (int k = 0; k < MB; k++) begin
      input_data[8*k +: 8] = (k < size) ? pay[k] : 8'($urandom);
    end
    input_data_size = 8'(size);
  endtask

  task automatic scramble();
    for (int k = 0; k < MB; k++) input_data[8*k +: 8] = 8'($urandom);
    input_data_size = 8'($urandom);
  endtask

  // mode 0: ready always high; 1: random ready plus stray starts; 2: ready pattern 1,0,0 repeating
  task automatic do_xfer(input int size, input int mode, input string tag);
    logic [7:0] exp_q [$];
    logic [7:0] held;
    logic       r;
    logic       stalled;
    int         cyc;
    int         n;
    for (int k = 0; k < size; k++) exp_q.push_back(pay[k]);
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hEF);
    load_inputs(size);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    chk({tag, " first_valid"}, 32'(tx_valid), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " done_cleared"}, 32'(done), 32'd0);
    cyc = 0;
    n = 0;
    stalled = 1'b0;
    held = 8'h00;
    while (exp_q.size() > 0 && cyc < 4000) begin
      if (!tx_valid) break;
      if (stalled) chk({tag, " held"}, 32'(tx_data), 32'(held));
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (n % 3 == 0);
      endcase
      if (mode != 0 && $urandom_range(0, 4) == 0) begin
        start = 1'b1;
        input_data_size = 8'($urandom_range(1, MB));
      end else begin
        start = 1'b0;
      end
      tx_ready = r;
      if (r) chk({tag, " byte"}, 32'(tx_data), 32'(exp_q.pop_front()));
      held = tx_data;
      stalled = !r;
      n++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    tx_ready = 1'b0;
    chk({tag, " bytes_left"}, 32'(exp_q.size()), 32'd0);
    if (mode == 0) chk({tag, " cycles"}, 32'(cyc), 32'(size + 2));
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " error"}, 32'(error), 32'd0);
    chk({tag, " busy_end"}, 32'(busy), 32'd0);
    chk({tag, " valid_end"}, 32'(tx_valid), 32'd0);
  endtask

  initial begin
    logic saw;
    int   stalls;
    int   sz;
    reset = 1'b0;
    start = 1'b0;
    tx_ready = 1'b0;
    input_data = '0;
    input_data_size = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst tx_valid", 32'(tx_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst error", 32'(error), 32'd0);
    chk("rst tx_data", 32'(tx_data), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    do_xfer(3, 0, "basic");

    pay[0] = 8'hAA; pay[1] = 8'h55;
    do_xfer(2, 2, "backpressure");

    do_xfer(0, 0, "empty");

    for (int k = 0; k < MB; k++) pay[k] = 8'(k + 1);
    do_xfer(MB, 0, "max");

    input_data_size = 8'd129;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("oversize error", 32'(error), 32'd1);
    chk("oversize done", 32'(done), 32'd0);
    chk("oversize busy", 32'(busy), 32'd0);
    saw = 1'b0;
    repeat (8) begin
      if (tx_valid || busy) saw = 1'b1;
      @(negedge clk);
    end
    chk("oversize no_tx", 32'(saw), 32'd0);

    repeat (6) begin
      sz = $urandom_range(0, MB);
      for (int k = 0; k < MB; k++) begin
        case ($urandom_range(0, 5))
          0:       pay[k] = 8'hBE;
          1:       pay[k] = 8'hEF;
          default: pay[k] = 8'($urandom);
        endcase
      end
      do_xfer(sz, 1, "random");
    end

    for (int k = 0; k < MB; k++) pay[k] = 8'($urandom);
    load_inputs(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tx_ready = 1'b1;
    repeat (4) @(negedge clk);
    tx_ready = 1'b0;
    chk("timeout 5th byte", 32'(tx_data), 32'(pay[4]));
    stalls = 0;
    while (tx_valid && stalls < 3000) begin
      stalls++;
      @(negedge clk);
    end
    chk("timeout stall_cycles", 32'(stalls), 32'(TO));
    chk("timeout valid", 32'(tx_valid), 32'd0);
    chk("timeout error", 32'(error), 32'd1);
    chk("timeout done", 32'(done), 32'd0);
    chk("timeout busy", 32'(busy), 32'd0);
    pay[0] = 8'($urandom);
    do_xfer(1, 0, "after_timeout");

    for (int k = 0; k < MB; k++) pay[k] = 8'($urandom);
    load_inputs(10);
    start = 1'b1;
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      scramble();
      chk("midreset byte", 32'(tx_data), 32'(pay[i]));
      @(negedge clk);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tx_ready = 1'b0;
    chk("midreset valid", 32'(tx_valid), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset error", 32'(error), 32'd0);
    chk("midreset tx_data", 32'(tx_data), 32'd0);
    tx_ready = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      if (tx_valid || done || error) saw = 1'b1;
      @(negedge clk);
    end
    chk("midreset quiet", 32'(saw), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
